// File: rtl/mem_slice_arbiter.sv
// Round-robin arbiter that shares one memory_slice port between NREQ requesters.
// An in-order tag FIFO routes each read response back to the requester that issued it.
`timescale 1ns/1ps
module mem_slice_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*AW-1:0]         req_addr,
  input  logic [NREQ*DW-1:0]         req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic [AW-1:0]              m_addr,
  output logic [DW-1:0]              m_data,
  output logic                       m_we,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic [AW-1:0]              m_rsp_addr,
  input  logic [DW-1:0]              m_rsp_data,
  input  logic                       m_rsp_valid,
  output logic                       m_rsp_ready,
  output logic [AW-1:0]              rsp_addr,
  output logic [DW-1:0]              rsp_data,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                       proto_err
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(TAG_DEPTH);

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt;
  logic            found;
  logic [NREQ-1:0] eligible;

  logic [IW-1:0]   tag_mem [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IW-1:0]   head;

  logic            fire;
  logic            push;
  logic            pop;

  assign fifo_full  = (count == (PW+1)'(TAG_DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr];

  // Reads need a free tag slot; a pop in the same cycle does not free one early.
  assign eligible = req_valid & (req_we | {NREQ{!fifo_full}});

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    int unsigned cand;
    found = 1'b0;
    gnt   = rr_ptr;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(rr_ptr) + i) % NREQ;
      if (!found && eligible[cand]) begin
        found = 1'b1;
        gnt   = IW'(cand);
      end
    end
  end

  assign m_valid   = reset_n && found;
  assign m_addr    = req_addr[int'(gnt)*AW +: AW];
  assign m_data    = req_data[int'(gnt)*DW +: DW];
  assign m_we      = req_we[gnt];
  assign fire      = m_valid && m_ready;
  assign push      = fire && !m_we;
  assign req_ready = fire ? (NREQ'(1'b1) << gnt) : '0;

  assign m_rsp_ready = reset_n && !fifo_empty && rsp_ready[head];
  assign rsp_valid   = (reset_n && m_rsp_valid && !fifo_empty) ? (NREQ'(1'b1) << head) : '0;
  assign rsp_addr    = m_rsp_addr;
  assign rsp_data    = m_rsp_data;
  assign pop         = m_rsp_valid && m_rsp_ready;

  assign outstanding = count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (fire)
        rr_ptr <= (gnt == IW'(NREQ-1)) ? '0 : gnt + IW'(1);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (m_rsp_valid && fifo_empty)
        proto_err <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= gnt;
  end

endmodule

// File: tb/tb_mem_slice_arbiter.sv
// Directed bench for mem_slice_arbiter: a behavioural slice answers reads one cycle after
// acceptance, and a scoreboard of expected responses is filled at issue and drained at return.
`timescale 1ns/1ps
module tb_mem_slice_arbiter;

  localparam int NREQ      = 4;
  localparam int AW        = 12;
  localparam int DW        = 32;
  localparam int TAG_DEPTH = 4;
  localparam int OW        = $clog2(TAG_DEPTH) + 1;

  typedef struct {
    int             req;
    bit             we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } req_t;

  typedef struct {
    int             req;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } exp_t;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } rsp_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_data;
  logic               m_we;
  logic               m_valid;
  logic               m_ready;
  logic [AW-1:0]      m_rsp_addr;
  logic [DW-1:0]      m_rsp_data;
  logic               m_rsp_valid;
  logic               m_rsp_ready;
  logic [AW-1:0]      rsp_addr;
  logic [DW-1:0]      rsp_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [OW-1:0]      outstanding;
  logic               proto_err;

  mem_slice_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_we        (m_we),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_rsp_addr  (m_rsp_addr),
    .m_rsp_data  (m_rsp_data),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_ready (m_rsp_ready),
    .rsp_addr    (rsp_addr),
    .rsp_data    (rsp_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .outstanding (outstanding),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  req_t pend[$];
  exp_t exp_q[$];
  rsp_t slice_q[$];
  int   tagq[$];
  int   gnt_log[$];
  int   rsp_cnt[NREQ];

  int   rr      = 0;
  int   occ     = 0;
  int   max_out = 0;
  bit   perr    = 1'b0;
  bit   known   = 1'b0;
  bit   inject  = 1'b0;
  logic [DW-1:0] last_rsp_data2;
  logic [DW-1:0] slice_mem [0:4095];
  logic [DW-1:0] ref_mem   [0:4095];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_req(input int req, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    req_t r;
    r.req = req; r.we = we; r.addr = addr; r.data = data;
    pend.push_back(r);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NREQ; k++) rsp_cnt[k] = 0;
  endtask

  // Each requester presents its oldest pending request; the slice presents its oldest response.
  task automatic drive_inputs();
    logic [NREQ-1:0]    v;
    logic [NREQ-1:0]    w;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    v = '0; w = '0; a = '0; d = '0;
    for (int k = 0; k < NREQ; k++) begin
      bit got;
      got = 1'b0;
      for (int j = 0; j < pend.size(); j++) begin
        if (!got && pend[j].req == k) begin
          got = 1'b1;
          v[k] = 1'b1;
          w[k] = pend[j].we;
          a[k*AW +: AW] = pend[j].addr;
          d[k*DW +: DW] = pend[j].data;
        end
      end
    end
    req_valid = v;
    req_we    = w;
    req_addr  = a;
    req_data  = d;
    if (inject) begin
      m_rsp_valid = 1'b1;
      m_rsp_addr  = 12'hBAD;
      m_rsp_data  = 32'h0BAD_0BAD;
    end else if (slice_q.size() > 0) begin
      m_rsp_valid = 1'b1;
      m_rsp_addr  = slice_q[0].addr;
      m_rsp_data  = slice_q[0].data;
    end else begin
      m_rsp_valid = 1'b0;
      m_rsp_addr  = '0;
      m_rsp_data  = '0;
    end
  endtask

  // One clock: check at the falling edge, advance model and slice at the rising edge.
  task automatic tick();
    int              g;
    int              head;
    int              jdx;
    bit              found, full, empty, exp_mvalid, exp_mrr, fire_m, pop_m;
    bit              s_fire, s_we, s_pop;
    logic [NREQ-1:0] elig, exp_ready, exp_rspv;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_data;
    req_t            r;
    exp_t            e;

    drive_inputs();
    @(negedge clk);
    full  = (tagq.size() == TAG_DEPTH);
    empty = (tagq.size() == 0);
    head  = empty ? 0 : tagq[0];
    elig  = req_valid & (req_we | {NREQ{!full}});
    found = 1'b0;
    g     = rr;
    for (int i = 0; i < NREQ; i++) begin
      int c;
      c = (rr + i) % NREQ;
      if (!found && elig[c]) begin
        found = 1'b1;
        g     = c;
      end
    end
    exp_mvalid = reset_n && found;
    exp_ready  = (exp_mvalid && m_ready) ? (NREQ'(1) << g) : '0;
    exp_rspv   = (reset_n && m_rsp_valid && !empty) ? (NREQ'(1) << head) : '0;
    exp_mrr    = reset_n && !empty && rsp_ready[head];

    check("m_valid", m_valid, exp_mvalid);
    check("req_ready", req_ready, exp_ready);
    if (exp_mvalid) begin
      check("m_addr", m_addr, req_addr[g*AW +: AW]);
      check("m_data", m_data, req_data[g*DW +: DW]);
      check("m_we", m_we, req_we[g]);
    end
    check("rsp_valid", rsp_valid, exp_rspv);
    check("m_rsp_ready", m_rsp_ready, exp_mrr);
    if (known) begin
      check("outstanding", outstanding, occ);
      check("proto_err", proto_err, perr);
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
    end

    for (int k = 0; k < NREQ; k++) begin
      if (req_ready[k]) gnt_log.push_back(k);
      if (rsp_valid[k] && m_rsp_ready) rsp_cnt[k]++;
    end
    if (rsp_valid[2] && m_rsp_ready) last_rsp_data2 = rsp_data;

    fire_m = exp_mvalid && m_ready;
    pop_m  = m_rsp_valid && exp_mrr;
    if (pop_m && exp_q.size() > 0) begin
      check("rsp_addr", rsp_addr, exp_q[0].addr);
      check("rsp_data", rsp_data, exp_q[0].data);
    end

    s_fire = m_valid && m_ready;
    s_we   = m_we;
    s_addr = m_addr;
    s_data = m_data;
    s_pop  = m_rsp_valid && m_rsp_ready && !inject;

    @(posedge clk);
    if (!reset_n) begin
      rr = 0; occ = 0; perr = 1'b0; known = 1'b1;
      tagq.delete(); exp_q.delete(); slice_q.delete();
    end else begin
      if (fire_m) begin
        jdx = -1;
        for (int j = 0; j < pend.size(); j++)
          if (jdx < 0 && pend[j].req == g) jdx = j;
        r = pend[jdx];
        pend.delete(jdx);
        rr = (g + 1) % NREQ;
        if (!r.we) begin
          tagq.push_back(g);
          occ++;
          e.req = g; e.addr = r.addr; e.data = ref_mem[r.addr];
          exp_q.push_back(e);
        end else begin
          ref_mem[r.addr] = r.data;
        end
      end
      if (pop_m) begin
        void'(tagq.pop_front());
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        occ--;
      end
      if (m_rsp_valid && empty) perr = 1'b1;
      if (s_pop && slice_q.size() > 0) void'(slice_q.pop_front());
      if (s_fire) begin
        if (s_we) slice_mem[s_addr] = s_data;
        else      slice_q.push_back('{s_addr, slice_mem[s_addr]});
      end
    end
    #1;
    drive_inputs();
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while ((pend.size() > 0 || exp_q.size() > 0 || slice_q.size() > 0) && n < 60) begin
      tick();
      n++;
    end
    check("idle_timeout", (n < 60), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fair_order [5];
    fair_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4096; i++) begin
      slice_mem[i] = 32'hC0DE_0000 | i;
      ref_mem[i]   = 32'hC0DE_0000 | i;
    end
    last_rsp_data2 = '0;
    reset_n   = 1'b0;
    m_ready   = 1'b1;
    rsp_ready = '1;
    clear_counts();
    tick();
    tick();
    reset_n = 1'b1;
    check("reset_outstanding", outstanding, 0);
    check("reset_proto_err", proto_err, 0);

    // Fairness: four readers plus a second read from req0.
    gnt_log.delete();
    add_req(0, 1'b0, 12'h010, '0);
    add_req(1, 1'b0, 12'h020, '0);
    add_req(2, 1'b0, 12'h030, '0);
    add_req(3, 1'b0, 12'h040, '0);
    add_req(0, 1'b0, 12'h010, '0);
    run_idle();
    check("fair_count", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < gnt_log.size()) check($sformatf("fair_gnt%0d", i), gnt_log[i], fair_order[i]);
    check("fair_rsp0", rsp_cnt[0], 2);
    check("fair_rsp3", rsp_cnt[3], 1);

    // Write from req0, then read-back by req2.
    clear_counts();
    max_out = 0;
    add_req(0, 1'b1, 12'h100, 32'hDEAD_BEEF);
    tick();
    add_req(2, 1'b0, 12'h100, '0);
    run_idle();
    check("wr_rd_data", last_rsp_data2, 32'hDEAD_BEEF);
    check("wr_rd_peak", max_out, 1);
    check("wr_no_rsp_req0", rsp_cnt[0], 0);
    check("wr_rd_rsp_req2", rsp_cnt[2], 1);

    // Full tag FIFO: five reads from req1 with responses blocked.
    clear_counts();
    gnt_log.delete();
    rsp_ready = '0;
    for (int i = 0; i < 5; i++) add_req(1, 1'b0, 12'h200 + 12'(i), '0);
    repeat (4) tick();
    check("full_outstanding", outstanding, 4);
    check("full_ready1", req_ready[1], 1'b0);
    tick();
    check("full_hold", outstanding, 4);
    add_req(3, 1'b1, 12'h300, 32'h1234_5678);
    tick();
    check("full_wr_count", gnt_log.size(), 5);
    if (gnt_log.size() > 0) check("full_wr_gnt", gnt_log[gnt_log.size()-1], 3);
    rsp_ready[1] = 1'b1;
    tick();
    check("no_bypass_gnt", gnt_log.size(), 5);
    check("no_bypass_out", outstanding, 3);
    run_idle();
    check("full_rsp1", rsp_cnt[1], 5);
    check("full_total_gnt", gnt_log.size(), 6);
    check("full_drained", outstanding, 0);

    // Backpressure from the slice.
    rsp_ready = '1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_ready = 1'b0;
    gnt_log.delete();
    add_req(0, 1'b0, 12'h050, '0);
    add_req(1, 1'b0, 12'h060, '0);
    repeat (3) tick();
    check("bp_no_grant", gnt_log.size(), 0);
    m_ready = 1'b1;
    run_idle();
    check("bp_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("bp_first", gnt_log[0], 0);
      check("bp_second", gnt_log[1], 1);
    end

    // Response stall: tags 2 then 0, requester 2 not ready for two cycles.
    clear_counts();
    gnt_log.delete();
    rsp_ready[2] = 1'b0;
    add_req(2, 1'b0, 12'h0A0, '0);
    add_req(0, 1'b0, 12'h0B0, '0);
    repeat (3) tick();
    check("stall_m_rsp_ready", m_rsp_ready, 1'b0);
    check("stall_rsp_valid", rsp_valid, 4'b0100);
    check("stall_rsp0", rsp_cnt[0], 0);
    check("stall_outstanding", outstanding, 2);
    rsp_ready[2] = 1'b1;
    run_idle();
    check("stall_rsp2_done", rsp_cnt[2], 1);
    check("stall_rsp0_done", rsp_cnt[0], 1);

    // Reset with reads in flight, then a response with no tag.
    rsp_ready = '0;
    add_req(0, 1'b0, 12'h011, '0);
    add_req(1, 1'b0, 12'h021, '0);
    add_req(2, 1'b0, 12'h031, '0);
    repeat (3) tick();
    check("pre_reset_out", outstanding, 3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("post_reset_out", outstanding, 0);
    rsp_ready = '1;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check("proto_err_set", proto_err, 1'b1);
    repeat (3) tick();
    check("proto_err_sticky", proto_err, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("proto_err_clear", proto_err, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
